// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Two-flop input synchroniser, mid-bit sampling driven by a bit-period counter,
// start-bit glitch rejection and stop-bit validation with a break-wait state.
module uart_rx #(
    parameter int unsigned CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    output logic       rx_busy
);

    localparam logic [31:0] HalfLast = 32'(CLK_PER_HALF_BIT - 1);
    localparam logic [31:0] BitLast  = 32'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;  // selects which of the eight data-bit periods is active
    logic        rxd_meta_q;
    logic        rxd_s;

    // Two-flop synchroniser for the asynchronous pin; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s      <= rxd_meta_q;
        end
    end

    // Receive FSM with registered outputs; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            rdata     <= '0;
            rx_ready  <= 1'b0;
            ferr      <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            cnt_q    <= cnt_q + 32'd1;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rxd_s) begin
                        state_q <= StStart;
                        rx_busy <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (!rxd_s) begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: drop it silently.
                            state_q <= StIdle;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            rdata    <= shift_q;
                            rx_ready <= 1'b1;
                            state_q  <= StIdle;
                            rx_busy  <= 1'b0;
                        end else begin
                            ferr    <= 1'b1;
                            state_q <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    // Hold here until the line recovers so a long low raises one ferr only.
                    if (rxd_s) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at H=8 for the functional steps,
// one at the default H=434 for the baud smoke test.
module tb_uart_rx;

    localparam int unsigned HS  = 8;
    localparam int unsigned BS  = 2 * HS;
    localparam int unsigned HB  = 434;
    localparam int unsigned BB  = 2 * HB;

    logic       clk;
    logic       rst_a, rst_b;
    logic       rxd_a, rxd_b;
    logic [7:0] rdata_a, rdata_b;
    logic       rx_ready_a, rx_ready_b;
    logic       ferr_a, ferr_b;
    logic       rx_busy_a, rx_busy_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int n_ready_a = 0, n_ferr_a = 0, n_both_a = 0, ready_cyc_a = 0;
    int n_ready_b = 0, n_ferr_b = 0, ready_cyc_b = 0;
    logic [7:0] got_a[$];

    uart_rx #(.CLK_PER_HALF_BIT(HS)) u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .rxd      (rxd_a),
        .rdata    (rdata_a),
        .rx_ready (rx_ready_a),
        .ferr     (ferr_a),
        .rx_busy  (rx_busy_a)
    );

    uart_rx u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .rxd      (rxd_b),
        .rdata    (rdata_b),
        .rx_ready (rx_ready_b),
        .ferr     (ferr_b),
        .rx_busy  (rx_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_ready_a) begin
            n_ready_a   = n_ready_a + 1;
            ready_cyc_a = cyc;
            got_a.push_back(rdata_a);
        end
        if (ferr_a) n_ferr_a = n_ferr_a + 1;
        if (rx_ready_a && ferr_a) n_both_a = n_both_a + 1;
        if (rx_ready_b) begin
            n_ready_b   = n_ready_b + 1;
            ready_cyc_b = cyc;
        end
        if (ferr_b) n_ferr_b = n_ferr_b + 1;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds the level for n clocks.
    task automatic send_bit(input bit sel, input logic b, input int n);
        if (sel) rxd_b = b;
        else rxd_a = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input int n);
        send_bit(sel, 1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], n);
        send_bit(sel, stop, n);
    endtask

    int start_cyc;
    int base_ready;
    int base_ferr;
    logic [7:0] b12;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdata", 32'(rdata_a), 32'h00);
        check("rst_rx_ready", 32'(rx_ready_a), 32'h0);
        check("rst_ferr", 32'(ferr_a), 32'h0);
        check("rst_rx_busy", 32'(rx_busy_a), 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);

        // Frame 0xA5: rx_ready edge = 2 sync edges + idle-detect edge + H + 9*2H = 155 edges
        start_cyc = cyc;
        send_bit(1'b0, 1'b0, BS);
        check("a5_busy_mid", 32'(rx_busy_a), 32'h1);
        for (int i = 0; i < 8; i++) send_bit(1'b0, (i % 3 == 1 || i % 3 == 0) ? 1'bx : 1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 8'hA5 >> i & 8'h01 ? 1'b1 : 1'b0, BS);
        send_bit(1'b0, 1'b1, BS);
        check("a5_busy_after", 32'(rx_busy_a), 32'h0);
        repeat (4) @(negedge clk);
        check("a5_count", 32'(n_ready_a), 32'd1);
        check("a5_rdata", 32'(rdata_a), 32'hA5);
        check("a5_ferr", 32'(n_ferr_a), 32'd0);
        check("a5_latency", 32'(ready_cyc_a - start_cyc), 32'd155);

        // Short low glitch (5 cycles < H)
        send_bit(1'b0, 1'b0, 5);
        check("glitch_busy", 32'(rx_busy_a), 32'h1);
        send_bit(1'b0, 1'b1, 20);
        check("glitch_busy_clr", 32'(rx_busy_a), 32'h0);
        check("glitch_ready", 32'(n_ready_a), 32'd1);
        check("glitch_ferr", 32'(n_ferr_a), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b1, BS);
        send_bit(1'b0, 1'b1, 4);
        check("3c_count", 32'(n_ready_a), 32'd2);
        check("3c_rdata", 32'(rdata_a), 32'h3C);

        // Framing error then a long low: one ferr, rdata keeps the last good byte
        send_frame(1'b0, 8'h5A, 1'b0, BS);
        send_bit(1'b0, 1'b0, 50);
        check("brk_busy", 32'(rx_busy_a), 32'h1);
        check("brk_ferr_mid", 32'(n_ferr_a), 32'd1);
        send_bit(1'b0, 1'b0, 50);
        send_bit(1'b0, 1'b1, 20);
        check("brk_ferr", 32'(n_ferr_a), 32'd1);
        check("brk_ready", 32'(n_ready_a), 32'd2);
        check("brk_rdata", 32'(rdata_a), 32'h3C);
        check("brk_busy_clr", 32'(rx_busy_a), 32'h0);
        send_frame(1'b0, 8'h81, 1'b1, BS);
        send_bit(1'b0, 1'b1, 4);
        check("81_rdata", 32'(rdata_a), 32'h81);
        check("81_count", 32'(n_ready_a), 32'd3);

        // Back-to-back frames, single stop bit, no gap
        send_frame(1'b0, 8'h00, 1'b1, BS);
        send_frame(1'b0, 8'hFF, 1'b1, BS);
        send_frame(1'b0, 8'h55, 1'b1, BS);
        send_bit(1'b0, 1'b1, 20);
        check("b2b_count", 32'(n_ready_a), 32'd6);
        check("b2b_0", 32'(got_a[3]), 32'h00);
        check("b2b_1", 32'(got_a[4]), 32'hFF);
        check("b2b_2", 32'(got_a[5]), 32'h55);
        check("b2b_ferr", 32'(n_ferr_a), 32'd1);

        // Reset in the middle of data bit 4 of 0x12; the line keeps going
        b12 = 8'h12;
        base_ready = n_ready_a;
        send_bit(1'b0, 1'b0, BS);
        for (int i = 0; i < 4; i++) send_bit(1'b0, b12[i], BS);
        send_bit(1'b0, b12[4], BS / 2);
        rst_a = 1'b1;
        @(negedge clk);
        check("mrst_rdata", 32'(rdata_a), 32'h00);
        check("mrst_busy", 32'(rx_busy_a), 32'h0);
        check("mrst_ready", 32'(rx_ready_a), 32'h0);
        check("mrst_ferr", 32'(ferr_a), 32'h0);
        rst_a = 1'b0;
        send_bit(1'b0, b12[4], BS / 2 - 1);
        for (int i = 5; i < 8; i++) send_bit(1'b0, b12[i], BS);
        send_bit(1'b0, 1'b1, BS);
        // Let any resynchronisation on the frame tail settle before the next frame.
        send_bit(1'b0, 1'b1, 20 * BS);
        begin
            int seen12 = 0;
            for (int i = base_ready; i < got_a.size(); i++) if (got_a[i] == 8'h12) seen12++;
            check("mrst_no_12", 32'(seen12), 32'd0);
        end
        check("mrst_idle", 32'(rx_busy_a), 32'h0);
        send_frame(1'b0, 8'h34, 1'b1, BS);
        send_bit(1'b0, 1'b1, 4);
        check("34_rdata", 32'(rdata_a), 32'h34);
        check("never_both", 32'(n_both_a), 32'd0);

        // Default-parameter smoke test: 0xC3, 3 + 434 + 9*868 edges to rx_ready
        start_cyc = cyc;
        send_frame(1'b1, 8'hC3, 1'b1, BB);
        send_bit(1'b1, 1'b1, 4);
        check("c3_count", 32'(n_ready_b), 32'd1);
        check("c3_rdata", 32'(rdata_b), 32'hC3);
        check("c3_ferr", 32'(n_ferr_b), 32'd0);
        check("c3_latency", 32'(ready_cyc_b - start_cyc), 32'(3 + HB + 9 * BB));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
